// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the sequential-access memory controller.
// Optional parity storage is enabled with the MEM_SEQ_PARITY_EN macro.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    localparam int unsigned MAX_DW = 64;

    function automatic cmd_e decode_cmd(input logic we, input logic re);
        return cmd_e'({we, re});
    endfunction

    // Explicit compare so non-power-of-two depths never step past the end.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic logic even_par(input logic [MAX_DW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// Command/data bundle between a stream producer/consumer and mem_seq_ctrl.
// Same signal set whether or not MEM_SEQ_PARITY_EN is defined.
interface mem_seq_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          WE;
    logic          RE;
    logic [DW-1:0] DataIn;
    logic [AW-1:0] Addr;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          Wrap;
    logic          Full;
    logic          ParErr;

    modport master (
        output WE, RE, DataIn,
        input  Addr, DataOut, DataValid, Wrap, Full, ParErr
    );

    modport slave (
        input  WE, RE, DataIn,
        output Addr, DataOut, DataValid, Wrap, Full, ParErr
    );

endinterface

// File: rtl/mem_seq_ram.sv
// DEPTH-word storage with sync write and registered read; array is not reset.
// With MEM_SEQ_PARITY_EN each word carries an extra even-parity bit.
module mem_seq_ram
    import mem_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     perr_o
);
`ifdef MEM_SEQ_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] wword;
    logic [DW-1:0] rdata_q;
    logic          perr_q;

`ifdef MEM_SEQ_PARITY_EN
    assign wword = {even_par(MAX_DW'(wdata_i)), wdata_i};
`else
    assign wword = wdata_i;
`endif

    // Storage array: written on accepted WRITE commands only.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wword;
        end
    end

    // Read register holds its value between reads; error flag is a pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (re_i) begin
                rdata_q <= mem_q[addr_i][DW-1:0];
`ifdef MEM_SEQ_PARITY_EN
                perr_q  <= ^mem_q[addr_i];
`endif
            end
        end
    end

    assign rdata_o = rdata_q;
    assign perr_o  = perr_q;

endmodule

// File: rtl/mem_seq_ctrl.sv
// Sequential-access memory controller: shared auto-incrementing pointer,
// wrap pulse, write-fill tracking, clear. Parity via MEM_SEQ_PARITY_EN.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      Reset,
    mem_seq_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CMAX = CW'(DEPTH);

    cmd_e          cmd;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          wrap_q, wrap_d;
    logic          dv_q, dv_d;
    logic          ram_we, ram_re;
    logic [AW-1:0] ptr_inc;
    logic [DW-1:0] ram_rdata;
    logic          ram_perr;

    assign cmd     = decode_cmd(bus.WE, bus.RE);
    assign ptr_inc = AW'(next_ptr(32'(ptr_q), $unsigned(DEPTH)));

    // Command decode: next pointer, fill count, pulses and RAM strobes.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        wrap_d = 1'b0;
        dv_d   = 1'b0;
        ram_we = 1'b0;
        ram_re = 1'b0;
        unique case (1'b1)
            (cmd == CMD_WRITE): begin
                ram_we = 1'b1;
                ptr_d  = ptr_inc;
                wrap_d = (ptr_q == LAST);
                cnt_d  = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
                full_d = (cnt_d == CMAX);
            end
            (cmd == CMD_READ): begin
                ram_re = 1'b1;
                dv_d   = 1'b1;
                ptr_d  = ptr_inc;
                wrap_d = (ptr_q == LAST);
            end
            (cmd == CMD_CLEAR): begin
                ptr_d  = '0;
                cnt_d  = '0;
                full_d = 1'b0;
            end
            default: begin
            end
        endcase
        if (Reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // Pointer, fill counter and flag registers; reset overrides any command.
    always_ff @(posedge clock) begin
        if (Reset) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            wrap_q <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            wrap_q <= wrap_d;
            dv_q   <= dv_d;
        end
    end

    mem_seq_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clock),
        .rst_i   (Reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ptr_q),
        .wdata_i (bus.DataIn),
        .rdata_o (ram_rdata),
        .perr_o  (ram_perr)
    );

    assign bus.Addr      = ptr_q;
    assign bus.DataOut   = ram_rdata;
    assign bus.DataValid = dv_q;
    assign bus.Wrap      = wrap_q;
    assign bus.Full      = full_q;
`ifdef MEM_SEQ_PARITY_EN
    assign bus.ParErr    = ram_perr;
`else
    assign bus.ParErr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: DEPTH=4 and DEPTH=3 instances on one stimulus.
// Parity corruption case is compiled only with MEM_SEQ_PARITY_EN.
module tb_mem_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_seq_if #(.DW(8), .DEPTH(4)) bus4 ();
    mem_seq_if #(.DW(8), .DEPTH(3)) bus3 ();

    mem_seq_ctrl #(.DW(8), .DEPTH(4)) dut4 (
        .clock (clk),
        .Reset (rst),
        .bus   (bus4)
    );

    mem_seq_ctrl #(.DW(8), .DEPTH(3)) dut3 (
        .clock (clk),
        .Reset (rst),
        .bus   (bus3)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, index 0 = DEPTH 4, index 1 = DEPTH 3.
    int         m_ptr  [2];
    int         m_cnt  [2];
    bit         m_full [2];
    bit         m_wrap [2];
    bit         m_dv   [2];
    bit         m_perr [2];
    logic [7:0] m_dout [2];
    logic [7:0] m_mem  [2][4];
    bit         m_bad  [2][4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(int k, bit r, bit we, bit re,
                                       logic [7:0] din);
        int d;
        d = (k == 0) ? 4 : 3;
        m_dv[k]   = 0;
        m_wrap[k] = 0;
        m_perr[k] = 0;
        if (r) begin
            m_ptr[k]  = 0;
            m_cnt[k]  = 0;
            m_full[k] = 0;
            m_dout[k] = 8'h00;
        end else if (we && re) begin
            m_ptr[k]  = 0;
            m_cnt[k]  = 0;
            m_full[k] = 0;
        end else if (we) begin
            m_mem[k][m_ptr[k]] = din;
            m_bad[k][m_ptr[k]] = 0;
            m_wrap[k] = (m_ptr[k] + 1 == d);
            m_ptr[k]  = (m_ptr[k] + 1) % d;
            m_cnt[k]  = (m_cnt[k] < d) ? m_cnt[k] + 1 : d;
            m_full[k] = (m_cnt[k] == d);
        end else if (re) begin
            m_dout[k] = m_mem[k][m_ptr[k]];
            m_perr[k] = m_bad[k][m_ptr[k]];
            m_dv[k]   = 1;
            m_wrap[k] = (m_ptr[k] + 1 == d);
            m_ptr[k]  = (m_ptr[k] + 1) % d;
        end
    endfunction

    task automatic check_model();
        chk("m4_addr", bus4.Addr, m_ptr[0]);
        chk("m4_dout", bus4.DataOut, m_dout[0]);
        chk("m4_dv", bus4.DataValid, m_dv[0]);
        chk("m4_wrap", bus4.Wrap, m_wrap[0]);
        chk("m4_full", bus4.Full, m_full[0]);
        chk("m4_perr", bus4.ParErr, m_perr[0]);
        chk("m3_addr", bus3.Addr, m_ptr[1]);
        chk("m3_dout", bus3.DataOut, m_dout[1]);
        chk("m3_dv", bus3.DataValid, m_dv[1]);
        chk("m3_wrap", bus3.Wrap, m_wrap[1]);
        chk("m3_full", bus3.Full, m_full[1]);
        chk("m3_perr", bus3.ParErr, m_perr[1]);
        chk("m3_addr_range", 32'(bus3.Addr < 2'd3), 1);
    endtask

    // Apply one cycle to both instances, then compare against the model.
    task automatic drive(input bit r, input bit we, input bit re,
                         input logic [7:0] din);
        rst         = r;
        bus4.WE     = we;
        bus4.RE     = re;
        bus4.DataIn = din;
        bus3.WE     = we;
        bus3.RE     = re;
        bus3.DataIn = din;
        @(posedge clk);
        #1;
        model_step(0, r, we, re, din);
        model_step(1, r, we, re, din);
        check_model();
    endtask

    typedef struct {
        bit         r;
        bit         we;
        bit         re;
        logic [7:0] din;
        int         addr;
        logic [7:0] dout;
        bit         dv;
        bit         wrap;
        bit         full;
    } vec_t;

    vec_t tv [19];

    logic [7:0] a3_exp [5];
    bit         f3_exp [5];

    initial begin
        bus4.WE = 0; bus4.RE = 0; bus4.DataIn = 0;
        bus3.WE = 0; bus3.RE = 0; bus3.DataIn = 0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                m_mem[k][j] = 8'h00;
                m_bad[k][j] = 0;
            end
        end

        // Expected DEPTH=4 outputs after each edge.
        tv[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 8'h11, 1, 8'h00, 0, 0, 0};
        tv[2]  = '{0, 1, 0, 8'h22, 2, 8'h00, 0, 0, 0};
        tv[3]  = '{0, 1, 0, 8'h33, 3, 8'h00, 0, 0, 0};
        tv[4]  = '{0, 1, 0, 8'h44, 0, 8'h00, 0, 1, 1};
        tv[5]  = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1};
        tv[6]  = '{0, 0, 1, 8'h00, 1, 8'h11, 1, 0, 1};
        tv[7]  = '{0, 0, 1, 8'h00, 2, 8'h22, 1, 0, 1};
        tv[8]  = '{0, 0, 1, 8'h00, 3, 8'h33, 1, 0, 1};
        tv[9]  = '{0, 0, 1, 8'h00, 0, 8'h44, 1, 1, 1};
        tv[10] = '{0, 0, 0, 8'h00, 0, 8'h44, 0, 0, 1};
        tv[11] = '{0, 0, 1, 8'h00, 1, 8'h11, 1, 0, 1};
        tv[12] = '{0, 0, 1, 8'h00, 2, 8'h22, 1, 0, 1};
        tv[13] = '{0, 1, 0, 8'hA5, 3, 8'h22, 0, 0, 1};
        tv[14] = '{0, 1, 1, 8'h00, 0, 8'h22, 0, 0, 0};
        tv[15] = '{0, 0, 1, 8'h00, 1, 8'h11, 1, 0, 0};
        tv[16] = '{0, 0, 1, 8'h00, 2, 8'h22, 1, 0, 0};
        tv[17] = '{0, 0, 1, 8'h00, 3, 8'hA5, 1, 0, 0};
        tv[18] = '{0, 0, 0, 8'h00, 3, 8'hA5, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].r, tv[i].we, tv[i].re, tv[i].din);
            chk($sformatf("tv%0d_addr", i), bus4.Addr, tv[i].addr);
            chk($sformatf("tv%0d_dout", i), bus4.DataOut, tv[i].dout);
            chk($sformatf("tv%0d_dv", i), bus4.DataValid, tv[i].dv);
            chk($sformatf("tv%0d_wrap", i), bus4.Wrap, tv[i].wrap);
            chk($sformatf("tv%0d_full", i), bus4.Full, tv[i].full);
        end

        // DEPTH=3: five writes, pointer sequence and sticky Full.
        a3_exp = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        f3_exp = '{0, 0, 1, 1, 1};
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 8'h30 + 8'(i));
            chk($sformatf("d3_addr%0d", i), bus3.Addr, a3_exp[i]);
            chk($sformatf("d3_full%0d", i), bus3.Full, f3_exp[i]);
        end
        chk("d3_wrap_after3", 32'(m_wrap[1]), 0);

        // Reset while a write is presented: no write, data kept.
        drive(1, 0, 0, 8'h00);
        drive(0, 1, 0, 8'h5A);
        drive(0, 1, 0, 8'h6B);
        drive(1, 1, 0, 8'hFF);
        chk("rst_addr", bus4.Addr, 0);
        chk("rst_full", bus4.Full, 0);
        chk("rst_dv", bus4.DataValid, 0);
        drive(0, 0, 1, 8'h00);
        chk("rst_rd0", bus4.DataOut, 8'h5A);
        drive(0, 0, 1, 8'h00);
        chk("rst_rd1", bus4.DataOut, 8'h6B);
        drive(0, 0, 1, 8'h00);
        chk("rst_rd2_nowrite", 32'(bus4.DataOut != 8'hFF), 1);

`ifdef MEM_SEQ_PARITY_EN
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 8'hC0 + 8'(i));
        dut4.u_ram.mem_q[1][8] = ~dut4.u_ram.mem_q[1][8];
        m_bad[0][1] = 1;
        drive(0, 0, 1, 8'h00);
        chk("par_clean", bus4.ParErr, 0);
        drive(0, 0, 1, 8'h00);
        chk("par_err", bus4.ParErr, 1);
        chk("par_err_dv", bus4.DataValid, 1);
        drive(0, 0, 0, 8'h00);
        chk("par_pulse", bus4.ParErr, 0);
`endif

        // Randomised commands with occasional reset, model-checked.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
